// File: rtl/ula_pkg.sv
// Shared definitions for the ULA and its two-requester arbiter.
package ula_pkg;
    localparam int WIDTH = 8;

    localparam logic [1:0] COND_ADD = 2'b00;
    localparam logic [1:0] COND_SUB = 2'b01;
    localparam logic [1:0] COND_EQ  = 2'b10;
    localparam logic [1:0] COND_ONE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;
endpackage

// File: rtl/ula_arbiter_if.sv
// Request/response bus between the two requesters and the ULA arbiter.
interface ula_arbiter_if;
    logic [1:0]                 req_valid;
    logic [1:0]                 req_ready;
    logic [ula_pkg::WIDTH-1:0]  req_a0;
    logic [ula_pkg::WIDTH-1:0]  req_a1;
    logic [ula_pkg::WIDTH-1:0]  req_b0;
    logic [ula_pkg::WIDTH-1:0]  req_b1;
    logic [1:0]                 req_cond0;
    logic [1:0]                 req_cond1;
    logic [1:0]                 rsp_valid;
    logic [1:0]                 rsp_ready;
    logic [ula_pkg::WIDTH-1:0]  rsp_out;
    logic                       rsp_carry;

    modport master (
        output req_valid, req_a0, req_a1, req_b0, req_b1, req_cond0, req_cond1, rsp_ready,
        input  req_ready, rsp_valid, rsp_out, rsp_carry
    );

    modport slave (
        input  req_valid, req_a0, req_a1, req_b0, req_b1, req_cond0, req_cond1, rsp_ready,
        output req_ready, rsp_valid, rsp_out, rsp_carry
    );
endinterface

// File: rtl/ula.sv
// Combinational 8-bit ULA: add, subtract (CARRY = borrow), equality and one-check.
module ula #(
    parameter int WIDTH = ula_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_cond,
    output logic [WIDTH-1:0] o_out,
    output logic             o_carry
);
    import ula_pkg::*;

    logic [WIDTH:0] w_sum;

    // Compare ops report their flag on CARRY and leave OUT at zero.
    always_comb begin
        w_sum   = '0;
        o_out   = '0;
        o_carry = 1'b0;
        case (i_cond)
            COND_ADD: begin
                w_sum   = {1'b0, i_a} + {1'b0, i_b};
                o_out   = w_sum[WIDTH-1:0];
                o_carry = w_sum[WIDTH];
            end
            COND_SUB: begin
                w_sum   = {1'b0, i_a} - {1'b0, i_b};
                o_out   = w_sum[WIDTH-1:0];
                o_carry = w_sum[WIDTH];
            end
            COND_EQ:  o_carry = (i_a == i_b);
            default:  o_carry = (i_a == WIDTH'(1));
        endcase
    end
endmodule

// File: rtl/ula_arbiter.sv
// Round-robin arbiter/sequencer sharing one ULA between two requesters.
module ula_arbiter #(
    parameter int WIDTH = ula_pkg::WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ula_arbiter_if.slave     bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    import ula_pkg::*;

    state_e           r_state;
    state_e           w_next;
    logic             r_last;
    logic             r_id;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_cond;
    logic [WIDTH-1:0] r_out;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             w_any;
    logic             w_gnt;
    logic             w_done;
    logic [WIDTH-1:0] w_ula_out;
    logic             w_ula_carry;

    assign w_any  = |bus.req_valid;
    // Under contention the requester that did not win last time goes first.
    assign w_gnt  = (&bus.req_valid) ? ~r_last : bus.req_valid[1];
    assign w_done = bus.rsp_ready[r_id];

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_next = ST_EXEC;
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: if (w_done) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        if (r_state == ST_IDLE && w_any) bus.req_ready[w_gnt] = 1'b1;
        if (r_state == ST_RESP)          bus.rsp_valid[r_id]  = 1'b1;
        busy = (r_state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last  <= 1'b1;
            r_id    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_cond  <= '0;
            r_out   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_any) begin
                    r_id   <= w_gnt;
                    r_a    <= w_gnt ? bus.req_a1    : bus.req_a0;
                    r_b    <= w_gnt ? bus.req_b1    : bus.req_b0;
                    r_cond <= w_gnt ? bus.req_cond1 : bus.req_cond0;
                end
                ST_EXEC: begin
                    r_out   <= w_ula_out;
                    r_carry <= w_ula_carry;
                end
                ST_RESP: if (w_done) begin
                    r_last <= r_id;
                    if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    ula #(.WIDTH(WIDTH)) u_ula (
        .i_a     (r_a),
        .i_b     (r_b),
        .i_cond  (r_cond),
        .o_out   (w_ula_out),
        .o_carry (w_ula_carry)
    );

    assign bus.rsp_out   = r_out;
    assign bus.rsp_carry = r_carry;
    assign op_count      = r_cnt;
endmodule

// File: tb/tb_ula_arbiter.sv
// Randomized + directed bench for ula_arbiter against a transaction-level model.
module tb_ula_arbiter;
    import ula_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy, busy2;
    logic [15:0] op_count;
    logic [1:0]  op_count2;

    ula_arbiter_if u_if ();
    ula_arbiter_if u_if2 ();

    assign u_if2.req_valid = u_if.req_valid;
    assign u_if2.req_a0    = u_if.req_a0;
    assign u_if2.req_a1    = u_if.req_a1;
    assign u_if2.req_b0    = u_if.req_b0;
    assign u_if2.req_b1    = u_if.req_b1;
    assign u_if2.req_cond0 = u_if.req_cond0;
    assign u_if2.req_cond1 = u_if.req_cond1;
    assign u_if2.rsp_ready = u_if.rsp_ready;

    ula_arbiter #(.CNT_W(16)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(u_if.slave),  .busy(busy),  .op_count(op_count));
    ula_arbiter #(.CNT_W(2))  u_dut2 (.clk(clk), .rst_n(rst_n), .bus(u_if2.slave), .busy(busy2), .op_count(op_count2));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ULA from plain integer arithmetic; returns {carry, out}.
    function automatic logic [8:0] ula_ref(input logic [7:0] a, input logic [7:0] b, input logic [1:0] c);
        int s;
        case (c)
            COND_ADD: begin s = int'(a) + int'(b); return {s > 255, 8'(s & 255)}; end
            COND_SUB: begin s = int'(a) - int'(b); return {s < 0,   8'(s & 255)}; end
            COND_EQ:  return {a == b, 8'h00};
            default:  return {a == 8'h01, 8'h00};
        endcase
    endfunction

    // Transaction model: one op in flight, aged in cycles since its acceptance.
    bit         m_busy  = 0;
    int         m_age   = 0;
    int         m_owner = 0;
    bit         m_last  = 1;
    logic [8:0] m_res   = '0;
    logic [8:0] m_val   = '0;
    int         m_cnt   = 0;

    initial begin
        int exp_rr, exp_rv;
        @(posedge clk);
        forever begin
            @(negedge clk); #1;
            exp_rr = 0;
            exp_rv = 0;
            if (!m_busy) begin
                if (u_if.req_valid == 2'b11) exp_rr = m_last ? 1 : 2;
                else                         exp_rr = int'(u_if.req_valid);
            end else if (m_age >= 2) begin
                exp_rv = (m_owner == 1) ? 2 : 1;
            end
            chk("req_ready",  int'(u_if.req_ready), exp_rr);
            chk("rsp_valid",  int'(u_if.rsp_valid), exp_rv);
            chk("rsp_out",    int'(u_if.rsp_out),   int'(m_val[7:0]));
            chk("rsp_carry",  int'(u_if.rsp_carry), int'(m_val[8]));
            chk("busy",       int'(busy),           int'(m_busy));
            chk("op_count",   int'(op_count),       (m_cnt > 65535) ? 65535 : m_cnt);
            chk("op_count2",  int'(op_count2),      (m_cnt > 3) ? 3 : m_cnt);
            chk("rsp_valid2", int'(u_if2.rsp_valid), exp_rv);
            chk("req_ready2", int'(u_if2.req_ready), exp_rr);
            chk("rsp_out2",   int'({u_if2.rsp_carry, u_if2.rsp_out}), int'(m_val));
            chk("busy2",      int'(busy2),          int'(m_busy));
            if (!rst_n) begin
                m_busy = 0; m_age = 0; m_last = 1; m_val = '0; m_cnt = 0;
            end else if (!m_busy) begin
                if (exp_rr != 0) begin
                    m_owner = (exp_rr == 2) ? 1 : 0;
                    m_res   = m_owner ? ula_ref(u_if.req_a1, u_if.req_b1, u_if.req_cond1)
                                      : ula_ref(u_if.req_a0, u_if.req_b0, u_if.req_cond0);
                    m_busy  = 1;
                    m_age   = 1;
                end
            end else if (m_age == 1) begin
                m_age = 2;
                m_val = m_res;
            end else if (u_if.rsp_ready[m_owner]) begin
                m_busy = 0;
                m_last = (m_owner == 1);
                m_cnt++;
            end
        end
    end

    initial begin
        int         g[$];
        int         cnt0;
        logic [1:0] acc;
        logic [7:0] ra, rb;
        logic [1:0] rc;
        u_if.req_valid = 0; u_if.req_a0 = 0; u_if.req_a1 = 0; u_if.req_b0 = 0; u_if.req_b1 = 0;
        u_if.req_cond0 = 0; u_if.req_cond1 = 0; u_if.rsp_ready = 0;
        repeat (3) @(negedge clk);
        rst_n = 1; #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(op_count), 0);
        chk("rst_rsp_valid", int'(u_if.rsp_valid), 0);
        chk("rst_rsp_out", int'(u_if.rsp_out), 0);

        // single request from requester 0
        @(negedge clk);
        u_if.req_valid = 2'b01; u_if.req_a0 = 8'h06; u_if.req_b0 = 8'h60; u_if.req_cond0 = COND_ADD;
        u_if.rsp_ready = 2'b01; #1;
        chk("single_req_ready", int'(u_if.req_ready), 1);
        @(negedge clk); u_if.req_valid = 0; #1;
        chk("single_exec_busy", int'(busy), 1);
        chk("single_exec_rv", int'(u_if.rsp_valid), 0);
        @(negedge clk); #1;
        chk("single_rsp_valid", int'(u_if.rsp_valid), 1);
        chk("single_out", int'(u_if.rsp_out), 'h66);
        chk("single_carry", int'(u_if.rsp_carry), 0);
        @(negedge clk); #1;
        chk("single_count", int'(op_count), 1);

        // carry path from requester 1
        @(negedge clk);
        u_if.req_valid = 2'b10; u_if.req_a1 = 8'hFF; u_if.req_b1 = 8'h01; u_if.req_cond1 = COND_ADD;
        u_if.rsp_ready = 2'b10; #1;
        chk("carry_req_ready", int'(u_if.req_ready), 2);
        @(negedge clk); u_if.req_valid = 0;
        @(negedge clk); #1;
        chk("carry_rsp_valid", int'(u_if.rsp_valid), 2);
        chk("carry_out", int'(u_if.rsp_out), 0);
        chk("carry_carry", int'(u_if.rsp_carry), 1);

        // contention: four back-to-back ops, expect strict alternation from requester 0
        @(negedge clk);
        u_if.req_valid = 2'b11; u_if.rsp_ready = 2'b11;
        u_if.req_a0 = 8'h10; u_if.req_b0 = 8'h03; u_if.req_cond0 = COND_SUB;
        u_if.req_a1 = 8'h22; u_if.req_b1 = 8'h22; u_if.req_cond1 = COND_EQ;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (u_if.req_ready != 0) g.push_back((u_if.req_ready == 2'b10) ? 1 : 0);
        end
        chk("cont_ngrants", g.size(), 4);
        for (int k = 0; k < 4 && k < g.size(); k++) chk("cont_order", g[k], k % 2);
        @(negedge clk); u_if.req_valid = 0; #1;
        chk("cont_count", int'(op_count), 6);

        // backpressure: requester 0 stalls in RESP while requester 1 waits
        @(negedge clk);
        u_if.req_valid = 2'b01; u_if.req_a0 = 8'h80; u_if.req_b0 = 8'h80; u_if.req_cond0 = COND_ADD;
        u_if.rsp_ready = 2'b00; #1;
        chk("bp_req_ready", int'(u_if.req_ready), 1);
        @(negedge clk);
        u_if.req_valid = 2'b10; u_if.req_a1 = 8'h05; u_if.req_b1 = 8'h07; u_if.req_cond1 = COND_SUB;
        @(negedge clk);
        cnt0 = int'(op_count);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk("bp_rsp_valid", int'(u_if.rsp_valid), 1);
            chk("bp_out", int'({u_if.rsp_carry, u_if.rsp_out}), 'h100);
            chk("bp_req_ready", int'(u_if.req_ready), 0);
            chk("bp_busy", int'(busy), 1);
        end
        @(negedge clk); u_if.rsp_ready = 2'b01; #1;
        chk("bp_complete_no_grant", int'(u_if.req_ready), 0);
        @(negedge clk); #1;
        chk("bp_count_step", int'(op_count), cnt0 + 1);
        chk("bp_next_grant", int'(u_if.req_ready), 2);
        @(negedge clk); u_if.req_valid = 0; u_if.rsp_ready = 2'b11;
        @(negedge clk); #1;
        chk("bp_sub_out", int'({u_if.rsp_carry, u_if.rsp_out}), 'h1FE);

        // requester 0 op so that requester 1 owns the next contended grant
        @(negedge clk);
        u_if.req_valid = 2'b01; u_if.req_a0 = 8'h01; u_if.req_b0 = 8'h00; u_if.req_cond0 = COND_ONE;
        @(negedge clk); u_if.req_valid = 0;
        @(negedge clk); #1;
        chk("one_check", int'({u_if.rsp_carry, u_if.rsp_out}), 'h100);

        // reset in EXEC discards the op; first contended grant afterwards is requester 0
        @(negedge clk);
        u_if.req_valid = 2'b11; u_if.req_a0 = 8'h09; u_if.req_b0 = 8'h09; u_if.req_cond0 = COND_EQ;
        u_if.req_a1 = 8'h01; u_if.req_b1 = 8'h02; u_if.req_cond1 = COND_ADD; #1;
        chk("pre_rst_grant", int'(u_if.req_ready), 2);
        @(negedge clk); rst_n = 0; u_if.req_valid = 0; #1;
        chk("pre_rst_busy", int'(busy), 1);
        @(negedge clk); rst_n = 1; #1;
        chk("rst_mid_outputs", int'({u_if.req_ready, u_if.rsp_valid, u_if.rsp_carry, u_if.rsp_out, busy}), 0);
        chk("rst_mid_count", int'(op_count), 0);
        @(negedge clk); u_if.req_valid = 2'b11; #1;
        chk("post_rst_grant", int'(u_if.req_ready), 1);
        acc = u_if.req_ready;

        // randomized traffic, requesters hold data until accepted
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            rst_n = !(k < 450 && $urandom_range(0, 199) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!(u_if.req_valid[i] && !acc[i])) begin
                    ra = 8'($urandom);
                    rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
                    rc = 2'($urandom_range(0, 3));
                    if (i == 0) begin
                        u_if.req_valid[0] = ($urandom_range(0, 9) < 7);
                        u_if.req_a0 = ra; u_if.req_b0 = rb; u_if.req_cond0 = rc;
                    end else begin
                        u_if.req_valid[1] = ($urandom_range(0, 9) < 7);
                        u_if.req_a1 = ra; u_if.req_b1 = rb; u_if.req_cond1 = rc;
                    end
                end
            end
            u_if.rsp_ready = 2'($urandom_range(0, 3));
            #1;
            acc = u_if.req_ready & u_if.req_valid;
        end
        @(negedge clk); u_if.req_valid = 0; u_if.rsp_ready = 2'b11;
        repeat (4) @(negedge clk);
        #1;
        chk("sat_count", int'(op_count2), 3);
        chk("drain_busy", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
